// File: rtl/arm_enc_pkg.sv
// Shared types and helpers for the ARM data-processing instruction encoder.
// Holds the request layout, the cmd field constants and the word-packing function.
package arm_enc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_ORR = 3'd3,
    OP_BIC = 3'd4,
    OP_EOR = 3'd5,
    OP_CMP = 3'd6,
    OP_ILL = 3'd7
  } dp_op_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_BIC = 4'b1110;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  typedef struct packed {
    logic [3:0]  cond;
    logic        s;
    logic        i;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    dp_op_e      op;
  } dp_req_t;

  // CMP only sets flags, so S is forced on and the unused Rd field is zeroed.
  function automatic logic [31:0] encode_dp(input dp_req_t req);
    logic [3:0] cmd;
    logic       s_bit;
    logic [3:0] rd;
    cmd   = CMD_AND;
    s_bit = req.s;
    rd    = req.rd;
    case (req.op)
      OP_ADD:  cmd = CMD_ADD;
      OP_SUB:  cmd = CMD_SUB;
      OP_ORR:  cmd = CMD_ORR;
      OP_BIC:  cmd = CMD_BIC;
      OP_EOR:  cmd = CMD_EOR;
      OP_CMP: begin
        cmd   = CMD_CMP;
        s_bit = 1'b1;
        rd    = 4'b0000;
      end
      default: cmd = CMD_AND;
    endcase
    return {req.cond, 2'b00, req.i, cmd, s_bit, req.rn, rd, req.src2};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; extra pointer bit
// distinguishes full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/dp_instr_encoder.sv
// Packs field-level DP requests into ARM machine words and streams them into
// instruction memory at consecutive word addresses, honouring write backpressure.
module dp_instr_encoder
  import arm_enc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [3:0]        req_cond,
  input  logic              req_s,
  input  logic              req_i,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [11:0]       req_src2,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              wrapped,
  output logic              illegal_op
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  dp_req_t req_in, fifo_head;
  logic    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic    accept, retire, load;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q,  out_data_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W:0]   count_q,     count_d;
  logic              wrapped_q,   wrapped_d;
  logic              illegal_q,   illegal_d;

  assign req_in = '{cond: req_cond, s: req_s, i: req_i, rn: req_rn, rd: req_rd,
                    src2: req_src2, op: dp_op_e'(req_op)};

  // Intake never bypasses a full FIFO, even when a pop frees a slot this cycle.
  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign fifo_push = accept && (req_in.op != OP_ILL) && !clear;
  assign retire    = out_valid_q && wr_ready;
  assign load      = !out_valid_q || retire;
  assign fifo_pop  = load && !fifo_empty && !clear;

  sync_fifo #(
    .WIDTH($bits(dp_req_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear),
    .push     (fifo_push),
    .push_data(req_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    addr_d      = addr_q;
    count_d     = count_q;
    wrapped_d   = wrapped_q;
    illegal_d   = illegal_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      addr_d      = BASE;
      count_d     = '0;
      wrapped_d   = 1'b0;
      illegal_d   = 1'b0;
    end else begin
      if (retire) begin
        addr_d = addr_q + 1'b1;
        if (addr_q == '1)         wrapped_d = 1'b1;
        if (count_q != CNT_MAX)   count_d   = count_q + 1'b1;
      end
      if (load) begin
        out_valid_d = !fifo_empty;
        if (!fifo_empty) out_data_d = encode_dp(fifo_head);
      end
      if (accept && req_in.op == OP_ILL) illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= BASE;
      count_q     <= '0;
      wrapped_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      wrapped_q   <= wrapped_d;
      illegal_q   <= illegal_d;
    end
  end

  assign wr_valid   = out_valid_q;
  assign wr_data    = out_data_q;
  assign wr_addr    = addr_q;
  assign word_count = count_q;
  assign wrapped    = wrapped_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_dp_instr_encoder.sv
// Scoreboard bench for dp_instr_encoder: the driver queues expected {addr,data}
// per accepted request, a negedge monitor checks every retired write.
module tb_dp_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 1 << ADDR_W;

  localparam logic [3:0] CMD_TAB [0:6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100,
                                           4'b1110, 4'b0001, 4'b1010};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, clear, req_valid, req_ready;
  logic [2:0]        req_op;
  logic [3:0]        req_cond, req_rn, req_rd;
  logic              req_s, req_i;
  logic [11:0]       req_src2;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   word_count;
  logic              wrapped, illegal_op;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   model_addr = 0;
  int   model_writes = 0;
  bit   model_illegal = 0;
  bit   rand_done = 0;

  always #5 clk = ~clk;

  dp_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_cond  (req_cond),
    .req_s     (req_s),
    .req_i     (req_i),
    .req_rn    (req_rn),
    .req_rd    (req_rd),
    .req_src2  (req_src2),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .word_count(word_count),
    .wrapped   (wrapped),
    .illegal_op(illegal_op)
  );

  function automatic logic [31:0] modelWord(input int op, input int cond, input int s,
                                            input int i, input int rn, input int rd,
                                            input int src2);
    logic [31:0] w;
    int s_v, rd_v;
    s_v  = (op == 6) ? 1 : s;
    rd_v = (op == 6) ? 0 : rd;
    w = (32'(cond) << 28) | (32'(i) << 25) | (32'(CMD_TAB[op]) << 21) |
        (32'(s_v) << 20) | (32'(rn) << 16) | (32'(rd_v) << 12) | 32'(src2);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && !clear && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        checkOutput("wr_data", wr_data, mon_e.data);
        model_writes++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input int op, input int cond, input int s, input int i,
                               input int rn, input int rd, input int src2,
                               input bit use_lit, input logic [31:0] lit);
    bit   acc;
    exp_t e;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_op    = 3'(op);
    req_cond  = 4'(cond);
    req_s     = 1'(s);
    req_i     = 1'(i);
    req_rn    = 4'(rn);
    req_rd    = 4'(rd);
    req_src2  = 12'(src2);
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      checkOutput("req_timeout", 32'd0, 32'd1);
    end else if (op == 7) begin
      model_illegal = 1'b1;
    end else begin
      e.addr = ADDR_W'(model_addr);
      e.data = use_lit ? lit : modelWord(op, cond, s, i, rn, rd, src2);
      exp_q.push_back(e);
      model_addr = (model_addr + 1) % NWORDS;
    end
  endtask

  task automatic randomReq(input bit allow_ill);
    int op;
    op = allow_ill ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
    applyStimulus(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)), 1'b0, 32'd0);
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    exp_q.delete();
    model_addr    = 0;
    model_writes  = 0;
    model_illegal = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"},  32'(req_ready),  32'd1);
    checkOutput({tag, "_wr_valid"},   32'(wr_valid),   32'd0);
    checkOutput({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    checkOutput({tag, "_wr_data"},    wr_data,         32'd0);
    checkOutput({tag, "_word_count"}, 32'(word_count), 32'd0);
    checkOutput({tag, "_wrapped"},    32'(wrapped),    32'd0);
    checkOutput({tag, "_illegal_op"}, 32'(illegal_op), 32'd0);
  endtask

  task automatic checkCounters(input string tag);
    int exp_count;
    exp_count = (model_writes > NWORDS) ? NWORDS : model_writes;
    checkOutput({tag, "_word_count"}, 32'(word_count), 32'(exp_count));
    checkOutput({tag, "_wrapped"},    32'(wrapped),    32'(model_writes >= NWORDS));
    checkOutput({tag, "_illegal_op"}, 32'(illegal_op), 32'(model_illegal));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; req_valid = 1'b0; wr_ready = 1'b0;
    req_op = '0; req_cond = '0; req_s = 1'b0; req_i = 1'b0;
    req_rn = '0; req_rd = '0; req_src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk);
    #1;

    // Spec-level encodings with latency check on the first word.
    wr_ready = 1'b1;
    applyStimulus(0, 14, 0, 1, 2, 1, 5, 1'b1, 32'hE2821005);
    @(negedge clk);
    checkOutput("latency_n1_wr_valid", 32'(wr_valid), 32'd0);
    @(negedge clk);
    checkOutput("latency_n2_wr_valid", 32'(wr_valid), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1, 14, 1, 0, 4, 3, 5, 1'b1, 32'hE0543005);
    applyStimulus(6, 14, 0, 1, 0, 7, 0, 1'b1, 32'hE3500000);
    applyStimulus(5, 0, 0, 0, 0, 0, 0, 1'b1, 32'h00200000);
    waitDrain();
    checkCounters("directed");

    applyStimulus(7, 14, 1, 1, 1, 1, 1, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("illegal_no_write", 32'(wr_valid), 32'd0);
    checkCounters("illegal");

    // Five requests against a stalled port: four queued plus one in the out stage.
    wr_ready = 1'b0;
    repeat (5) randomReq(1'b0);
    @(negedge clk);
    checkOutput("full_req_ready", 32'(req_ready), 32'd0);
    checkOutput("full_wr_valid",  32'(wr_valid),  32'd1);
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checkOutput("burst_wr_valid", 32'(wr_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    waitDrain();
    checkCounters("burst");

    fork
      begin
        for (int n = 0; n < 110; n++) randomReq(1'b1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          wr_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wr_ready = 1'b1;
    waitDrain();
    checkCounters("random");

    // Clear while a word is stalled and two more are queued.
    wr_ready = 1'b0;
    repeat (3) randomReq(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_clear_wr_valid", 32'(wr_valid), 32'd1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    checkResetValues("clear");
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    randomReq(1'b0);
    waitDrain();
    checkCounters("post_clear");

    wr_ready = 1'b0;
    repeat (2) randomReq(1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    @(negedge clk);
    checkResetValues("reset_mid");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
